// File: rtl/fpu_pkg.sv
// Shared FPU widths and constants for the add/sub datapath.
// GRS_W counts the guard, round and sticky bits carried below the significand.
package fpu_pkg;
   localparam int SIG_W   = 24;
   localparam int EXP_W   = 8;
   localparam int GRS_W   = 3;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam int LZC_W   = 5;
endpackage

// File: rtl/leading_zero_counter_27.sv
// Purely combinational leading-zero count of a 27-bit word; all-zero input yields 27.
// No latency, no flow control.
module leading_zero_counter_27 (
   input  logic [26:0] value,
   output logic [4:0]  count
);

   // Ascending scan: the highest set bit is the last to write, so it wins.
   always_comb begin
      count = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (value[i]) begin
            count = 5'(26 - i);
         end
      end
   end

endmodule

// File: rtl/fpu_normalize_shift_left.sv
// Post-adder normalizer: carry right-shift or left-shift by leading zeros, clamped at the denormal boundary.
// Two-stage valid/ready pipeline, 2-cycle latency, full throughput; a stalled output stalls both stages.
module fpu_normalize_shift_left
   import fpu_pkg::*;
#(
   parameter int SIG_W = fpu_pkg::SIG_W,
   parameter int EXP_W = fpu_pkg::EXP_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIG_W+3:0]         sig_in,
   input  logic [EXP_W-1:0]         exp_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIG_W+2:0]         sig_out,
   output logic [EXP_W-1:0]         exp_out,
   output logic                     zero,
   output logic                     overflow
);

   localparam int IN_W  = SIG_W + GRS_W + 1;
   localparam int OUT_W = SIG_W + GRS_W;
   localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX);
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   logic              s1_valid;
   logic              s1_ready;
   logic [IN_W-1:0]   s1_sig;
   logic [EXP_W-1:0]  s1_exp;
   logic [LZC_W-1:0]  s1_lzc;
   logic [LZC_W-1:0]  lzc;

   logic              s2_valid;
   logic              s2_ready;
   logic [OUT_W-1:0]  s2_sig;
   logic [EXP_W-1:0]  s2_exp;
   logic              s2_zero;
   logic              s2_ovf;

   logic              carry;
   logic [OUT_W-1:0]  body;
   logic [OUT_W-1:0]  shifted;
   logic [EXP_W-1:0]  exp_inc;
   logic [EXP_W-1:0]  exp_dec1;
   logic [EXP_W-1:0]  lzc_ext;
   logic [EXP_W-1:0]  shift;
   logic [OUT_W-1:0]  nxt_sig;
   logic [EXP_W-1:0]  nxt_exp;
   logic              nxt_zero;
   logic              nxt_ovf;

   leading_zero_counter_27 u_lzc (
      .value (sig_in[OUT_W-1:0]),
      .count (lzc)
   );

   assign s2_ready  = !s2_valid || out_ready;
   assign s1_ready  = !s1_valid || s2_ready;
   assign in_ready  = s1_ready;
   assign out_valid = s2_valid;
   assign sig_out   = s2_sig;
   assign exp_out   = s2_exp;
   assign zero      = s2_zero;
   assign overflow  = s2_ovf;

   always_comb begin
      carry    = s1_sig[IN_W-1];
      body     = s1_sig[OUT_W-1:0];
      exp_inc  = s1_exp + EXP_ONE;
      exp_dec1 = s1_exp - EXP_ONE;
      lzc_ext  = EXP_W'(s1_lzc);
      // Never shift the exponent below 1; whatever remains unnormalized is a denormal.
      shift    = (lzc_ext < exp_dec1) ? lzc_ext : exp_dec1;
      shifted  = body << shift;
      nxt_sig  = '0;
      nxt_exp  = '0;
      nxt_zero = 1'b0;
      nxt_ovf  = 1'b0;
      if (s1_sig == '0) begin
         nxt_zero = 1'b1;
      end else if (carry) begin
         nxt_exp = exp_inc;
         if (exp_inc == EXP_TOP) begin
            nxt_ovf = 1'b1;
         end else begin
            nxt_sig = {s1_sig[IN_W-1:2], |s1_sig[1:0]};
         end
      end else begin
         nxt_sig = shifted;
         nxt_exp = shifted[OUT_W-1] ? (s1_exp - shift) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sig   <= '0;
         s1_exp   <= '0;
         s1_lzc   <= '0;
         s2_valid <= 1'b0;
         s2_sig   <= '0;
         s2_exp   <= '0;
         s2_zero  <= 1'b0;
         s2_ovf   <= 1'b0;
      end else begin
         if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sig <= sig_in;
               s1_exp <= exp_in;
               s1_lzc <= lzc;
            end
         end
         if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sig  <= nxt_sig;
               s2_exp  <= nxt_exp;
               s2_zero <= nxt_zero;
               s2_ovf  <= nxt_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_normalize_shift_left.sv
// Bench for fpu_normalize_shift_left: directed vector table, backpressure and reset sequences,
// and randomized traffic checked by an in-order scoreboard fed from an arithmetic reference model.
module tb_fpu_normalize_shift_left;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] sig_in;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic        out_ready;
   logic [26:0] sig_out;
   logic [7:0]  exp_out;
   logic        zero;
   logic        overflow;

   always #5 clk = ~clk;

   fpu_normalize_shift_left dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sig_in    (sig_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sig_out   (sig_out),
      .exp_out   (exp_out),
      .zero      (zero),
      .overflow  (overflow)
   );

   typedef struct {
      logic [26:0] sig;
      logic [7:0]  e;
      logic        z;
      logic        o;
   } res_t;

   typedef struct {
      logic [27:0] sig;
      logic [7:0]  e;
      res_t        x;
   } vec_t;

   res_t q[$];
   res_t nxt;
   vec_t tbl[12];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out = 0;
   bit   in_fired;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: find the leading one arithmetically and apply the normalization rules directly.
   function automatic res_t model(input logic [27:0] s, input logic [7:0] e);
      res_t   r;
      longint v, p, lz, sh, ee;
      r.sig = '0; r.e = '0; r.z = 1'b0; r.o = 1'b0;
      v  = longint'(s);
      ee = longint'(e);
      if (v == 0) begin
         r.z = 1'b1;
      end else if (v >= (longint'(1) << 27)) begin
         if (ee + 1 == 255) begin
            r.o = 1'b1;
            r.e = 8'd255;
         end else begin
            r.sig = 27'(((v / 4) * 2) + ((v % 4) != 0 ? 1 : 0));
            r.e   = 8'(ee + 1);
         end
      end else begin
         p = 0;
         while ((v >> (p + 1)) != 0) p++;
         lz = 26 - p;
         sh = (lz < ee - 1) ? lz : ee - 1;
         r.sig = 27'(v * (longint'(1) << sh));
         r.e   = (r.sig >= 27'h4000000) ? 8'(ee - sh) : 8'd0;
      end
      return r;
   endfunction

   // Drive at posedge+1, evaluate handshakes at the negedge, return at the next posedge+1.
   task automatic cycle();
      in_fired = 1'b0;
      #4;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("sig_out", 32'(sig_out), 32'(q[0].sig));
               chk("exp_out", 32'(exp_out), 32'(q[0].e));
               chk("zero", 32'(zero), 32'(q[0].z));
               chk("overflow", 32'(overflow), 32'(q[0].o));
               if (out_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(nxt);
            in_fired = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [27:0] s, input logic [7:0] e);
      sig_in = s;
      exp_in = e;
      nxt    = model(s, e);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n0;
      int sent;
      int budget;
      bit have;
      logic [27:0] rs;
      logic [7:0]  re;
      int k;

      tbl[0]  = '{28'h8000000, 8'd127, '{27'h4000000, 8'd128, 1'b0, 1'b0}};
      tbl[1]  = '{28'h0000010, 8'd100, '{27'h4000000, 8'd78,  1'b0, 1'b0}};
      tbl[2]  = '{28'h0000010, 8'd10,  '{27'h0002000, 8'd0,   1'b0, 1'b0}};
      tbl[3]  = '{28'h0000000, 8'd50,  '{27'h0000000, 8'd0,   1'b1, 1'b0}};
      tbl[4]  = '{28'h8000000, 8'd254, '{27'h0000000, 8'd255, 1'b0, 1'b1}};
      tbl[5]  = '{28'hC000003, 8'd20,  '{27'h6000001, 8'd21,  1'b0, 1'b0}};
      tbl[6]  = '{28'h4000000, 8'd5,   '{27'h4000000, 8'd5,   1'b0, 1'b0}};
      tbl[7]  = '{28'h0000001, 8'd1,   '{27'h0000001, 8'd0,   1'b0, 1'b0}};
      tbl[8]  = '{28'h0000001, 8'd27,  '{27'h4000000, 8'd1,   1'b0, 1'b0}};
      tbl[9]  = '{28'h0000001, 8'd26,  '{27'h2000000, 8'd0,   1'b0, 1'b0}};
      tbl[10] = '{28'h8000004, 8'd253, '{27'h4000002, 8'd254, 1'b0, 1'b0}};
      tbl[11] = '{28'h7FFFFFF, 8'd3,   '{27'h7FFFFFF, 8'd3,   1'b0, 1'b0}};

      // Reset with a beat offered: it must be ignored.
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      set_beat(28'h8000000, 8'd127);
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sig_out", 32'(sig_out), 32'd0);
      chk("rst_exp_out", 32'(exp_out), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      cycle();
      cycle();
      chk("rst_ignored_beat", 32'(out_valid), 32'd0);

      // Directed vectors one at a time, with latency check.
      for (int i = 0; i < 12; i++) begin
         sig_in = tbl[i].sig;
         exp_in = tbl[i].e;
         nxt = tbl[i].x;
         in_valid = 1'b1;
         cycle();
         chk("vec_accept", 32'(in_fired), 32'd1);
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 8) begin
            cycle();
            n++;
         end
         chk("vec_latency", 32'(n), 32'd2);
         cycle();
         chk("vec_drained", 32'(q.size()), 32'd0);
      end

      // Same vectors back to back: one accepted per cycle.
      n0 = n_out;
      for (int i = 0; i < 12; i++) begin
         sig_in = tbl[i].sig;
         exp_in = tbl[i].e;
         nxt = tbl[i].x;
         in_valid = 1'b1;
         cycle();
         chk("tput_accept", 32'(in_fired), 32'd1);
      end
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 10) begin
         cycle();
         n++;
      end
      chk("tput_count", 32'(n_out - n0), 32'd12);

      // Backpressure: three beats, output stalled four cycles.
      out_ready = 1'b0;
      n0 = n_out;
      in_valid = 1'b1;
      set_beat(28'h8000000, 8'd127);
      cycle();
      chk("bp_accept_a", 32'(in_fired), 32'd1);
      set_beat(28'h0000010, 8'd100);
      cycle();
      chk("bp_accept_b", 32'(in_fired), 32'd1);
      set_beat(28'h0000010, 8'd10);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      cycle();
      chk("bp_hold_1", 32'(in_fired), 32'd0);
      cycle();
      chk("bp_hold_2", 32'(in_fired), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!in_fired && n < 10);
      chk("bp_accept_c_on_drain", 32'(n), 32'd1);
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 10) begin
         cycle();
         n++;
      end
      chk("bp_all_out", 32'(n_out - n0), 32'd3);

      // Reset with both stages full.
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_beat(28'h0000123, 8'd60);
      cycle();
      set_beat(28'h8000001, 8'd40);
      cycle();
      chk("mid_full_valid", 32'(out_valid), 32'd1);
      chk("mid_full_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      set_beat(28'h0000777, 8'd90);
      cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_sig_out", 32'(sig_out), 32'd0);
      chk("mid_rst_exp_out", 32'(exp_out), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
      end

      // Randomized traffic with random backpressure.
      sent = 0;
      have = 1'b0;
      budget = 0;
      n0 = n_out;
      while ((sent < 2000 || have || q.size() != 0) && budget < 30000) begin
         if (!have && sent < 2000 && $urandom_range(0, 9) < 7) begin
            k  = $urandom_range(0, 9);
            re = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 3) == 0) re = 8'($urandom_range(1, 30));
            if (k == 0) begin
               rs = '0;
            end else if (k <= 3) begin
               rs = {1'b1, 27'($urandom)};
               if (k == 1) re = 8'($urandom_range(252, 254));
            end else begin
               rs = 28'((32'($urandom) & 32'h7FFFFFF) >> $urandom_range(0, 26));
            end
            set_beat(rs, re);
            have = 1'b1;
         end
         in_valid  = have;
         out_ready = ($urandom_range(0, 9) < 6);
         cycle();
         budget++;
         if (in_fired) begin
            have = 1'b0;
            sent++;
         end
      end
      chk("rand_sent", 32'(sent), 32'd2000);
      chk("rand_received", 32'(n_out - n0), 32'd2000);
      chk("rand_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fpu_normalize_shift_left.md
FPU_NORMALIZE_SHIFT_LEFT -- requirements
Module: fpu_normalize_shift_left

Interface
REQ-001 SHALL have parameter SIG_W, default 24, significand width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts beat this cycle.
REQ-007 SHALL have port sig_in, input, SIG_W+4, {carry, significand, guard, round, sticky} raw adder result.
REQ-008 SHALL have port exp_in, input, EXP_W, effective biased exponent of larger operand, range 1..2^EXP_W-2.
REQ-009 SHALL have port out_valid, output, 1, result beat present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port sig_out, output, SIG_W+3, {normalized significand, guard, round, sticky}.
REQ-012 SHALL have port exp_out, output, EXP_W, adjusted biased exponent.
REQ-013 SHALL have port zero, output, 1, exact-zero result; port overflow, output, 1, exponent reached 2^EXP_W-1.

Function
REQ-014 SHALL be a two-stage valid/ready pipeline: stage 1 registers sig_in, exp_in and leading-zero count; stage 2 registers shifted result and flags.
REQ-015 SHALL transfer a beat on any interface only when valid and ready are both 1 in the same cycle.
REQ-016 SHALL compute s2_ready = !s2_valid | out_ready, s1_ready = !s1_valid | s2_ready, in_ready = s1_ready (combinational, no dependence on in_valid).
REQ-017 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready is held 1; throughput 1 beat/cycle.
REQ-018 SHALL hold out_valid and all result outputs stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, when carry bit (sig_in MSB) = 1: sig_out = {sig_in[MSB:2], sig_in[1]|sig_in[0]}, exp_out = exp_in+1.
REQ-020 SHALL, if carry case yields exp_out = 2^EXP_W-1: overflow=1, sig_out=0.
REQ-021 SHALL, when sig_in = 0: zero=1, exp_out=0, sig_out=0, overflow=0.
REQ-022 SHALL otherwise take lzc = leading zeros of sig_in[SIG_W+2:0] (0..SIG_W+2), shift = min(lzc, exp_in-1), sig_out = sig_in[SIG_W+2:0] << shift, exp_out = exp_in - shift.
REQ-023 SHALL set exp_out=0 when post-shift sig_out MSB = 0 (denormal result).
REQ-024 SHALL keep beats in order; no beat dropped or duplicated under any valid/ready pattern.
REQ-025 SHALL accept a new beat in the same cycle a result leaves when the pipeline is full.

Reset
REQ-026 SHALL clear s1_valid, s2_valid, out_valid to 0 on rst=1 at clock edge, discarding in-flight beats.
REQ-027 SHALL drive sig_out=0, exp_out=0, zero=0, overflow=0 after reset until the first result.
REQ-028 SHALL ignore in_valid during the cycle rst=1; in_ready SHALL read 1 the cycle after reset.

Structure
REQ-029 SHALL take SIG_W, EXP_W, EXP_MAX and GRS_W=3 constants from shared package fpu_pkg.
REQ-030 SHALL instantiate one sub-module leading_zero_counter_27 (combinational, 27-bit in, 5-bit count, all-zero in gives 27).

Verification
REQ-031 SHALL cover carry: sig_in=28'h8000000, exp_in=127 -> 2 cycles later sig_out=27'h4000000, exp_out=128, zero=0, overflow=0.
REQ-032 SHALL cover cancellation: sig_in=28'h0000010, exp_in=100 -> sig_out=27'h4000000, exp_out=78.
REQ-033 SHALL cover denormal clamp: sig_in=28'h0000010, exp_in=10 -> sig_out=27'h0002000, exp_out=0.
REQ-034 SHALL cover zero and overflow: sig_in=0, exp_in=50 -> zero=1, exp_out=0; sig_in=28'h8000000, exp_in=254 -> overflow=1, exp_out=255, sig_out=0.
REQ-035 SHALL cover backpressure: 3 back-to-back beats, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, then all 3 results in order, none lost.
REQ-036 SHALL cover reset mid-stream: rst=1 with both stages valid -> out_valid=0 next cycle, no stale result emitted afterward.
